// File: rtl/pipeline_id_stage_pkg.sv
// Shared decode constants and sizing helpers for the ID stage and its register file.
package pipeline_id_stage_pkg;

    localparam logic [5:0] OP_RTYPE = 6'd0;
    localparam logic [5:0] OP_BLTZ  = 6'd1;
    localparam logic [5:0] OP_BEQ   = 6'd4;
    localparam logic [5:0] OP_BNE   = 6'd5;
    localparam logic [5:0] OP_BLEZ  = 6'd6;
    localparam logic [5:0] OP_BGTZ  = 6'd7;

    localparam logic [5:0] FN_JR    = 6'd8;
    localparam logic [5:0] FN_JALR  = 6'd9;

    function automatic int reg_idx_w(input int nreg);
        return (nreg > 1) ? $clog2(nreg) : 1;
    endfunction

endpackage

// File: rtl/pipeline_regfile.sv
// NREG x XLEN register file, two read ports, one write port; r0 is hardwired to zero and
// a write in the same cycle as a read of that register is visible on the read port.
module pipeline_regfile import pipeline_id_stage_pkg::*; #(
    parameter int XLEN = 32,
    parameter int NREG = 32,
    localparam int RW  = reg_idx_w(NREG)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            wr_en,
    input  logic [RW-1:0]   wr_reg,
    input  logic [XLEN-1:0] wr_data,
    input  logic [RW-1:0]   rd_a_reg,
    output logic [XLEN-1:0] rd_a_data,
    input  logic [RW-1:0]   rd_b_reg,
    output logic [XLEN-1:0] rd_b_data
);

    logic [XLEN-1:0] regs [NREG];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
        end else if (wr_en && (wr_reg != '0)) begin
            regs[wr_reg] <= wr_data;
        end
    end

    function automatic logic [XLEN-1:0] read_port(input logic [RW-1:0] r,
                                                  input logic [XLEN-1:0] stored);
        if (r == '0)                    return '0;
        else if (wr_en && (wr_reg == r)) return wr_data;
        else                            return stored;
    endfunction

    assign rd_a_data = read_port(rd_a_reg, regs[rd_a_reg]);
    assign rd_b_data = read_port(rd_b_reg, regs[rd_b_reg]);

endmodule

// File: rtl/pipeline_id_stage.sv
// Decode stage: operand fetch with MEM/WB forwarding, ID-stage branch/jr resolution,
// load-use and branch-operand stalls, and the registered ID/EX bundle.
module pipeline_id_stage import pipeline_id_stage_pkg::*; #(
    parameter int XLEN    = 32,
    parameter int NREG    = 32,
    parameter int CTL_W   = 24,
    parameter int FORWARD = 1,
    localparam int RW     = reg_idx_w(NREG)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             if_valid,
    input  logic [XLEN-1:0]  if_pc,
    input  logic [31:0]      if_instr,
    input  logic [CTL_W-1:0] dec_ctl,
    input  logic             dec_regwr,
    input  logic             dec_uses_rt,
    input  logic             ex_stall,
    input  logic             ex_wr_en,
    input  logic [RW-1:0]    ex_wr_reg,
    input  logic             ex_memrd,
    input  logic             mem_wr_en,
    input  logic [RW-1:0]    mem_wr_reg,
    input  logic [XLEN-1:0]  mem_data,
    input  logic             wb_wr_en,
    input  logic [RW-1:0]    wb_wr_reg,
    input  logic [XLEN-1:0]  wb_data,
    output logic             id_ready,
    output logic             redirect,
    output logic [XLEN-1:0]  redirect_pc,
    output logic             idex_valid,
    output logic [XLEN-1:0]  idex_pc,
    output logic [XLEN-1:0]  idex_bus_a,
    output logic [XLEN-1:0]  idex_bus_b,
    output logic [XLEN-1:0]  idex_imm,
    output logic [RW-1:0]    idex_rs,
    output logic [RW-1:0]    idex_rt,
    output logic [RW-1:0]    idex_wrreg,
    output logic             idex_regwr,
    output logic [CTL_W-1:0] idex_ctl
);

    logic [5:0]             op, funct;
    logic [RW-1:0]          rs, rt, rd;
    logic [15:0]            imm16;
    logic signed [XLEN-1:0] imm_sext;
    logic [XLEN-1:0]        br_target;
    logic [XLEN-1:0]        rf_a, rf_b;
    logic signed [XLEN-1:0] op_a, op_b;
    logic                   is_branch, is_jr, taken, hz;
    logic                   ex_hit_rs, ex_hit_rt, mem_hit_rs, mem_hit_rt;

    assign op       = if_instr[31:26];
    assign rs       = RW'(if_instr[25:21]);
    assign rt       = RW'(if_instr[20:16]);
    assign rd       = RW'(if_instr[15:11]);
    assign funct    = if_instr[5:0];
    assign imm16    = if_instr[15:0];
    assign imm_sext = {{(XLEN-16){imm16[15]}}, imm16};
    assign br_target = if_pc + {imm_sext[XLEN-3:0], 2'b00};

    pipeline_regfile #(.XLEN(XLEN), .NREG(NREG)) u_regfile (
        .clk       (clk),
        .reset     (reset),
        .wr_en     (wb_wr_en),
        .wr_reg    (wb_wr_reg),
        .wr_data   (wb_data),
        .rd_a_reg  (rs),
        .rd_a_data (rf_a),
        .rd_b_reg  (rt),
        .rd_b_data (rf_b)
    );

    function automatic logic [XLEN-1:0] sel_operand(input logic [RW-1:0] r,
                                                    input logic [XLEN-1:0] rf_val);
        if (r == '0)                                              return '0;
        else if ((FORWARD != 0) && mem_wr_en && (mem_wr_reg == r)) return mem_data;
        else if (wb_wr_en && (wb_wr_reg == r))                    return wb_data;
        else                                                      return rf_val;
    endfunction

    assign op_a = sel_operand(rs, rf_a);
    assign op_b = sel_operand(rt, rf_b);

    assign is_branch = (op == OP_BLTZ) || (op == OP_BEQ) || (op == OP_BNE) ||
                       (op == OP_BLEZ) || (op == OP_BGTZ);
    assign is_jr     = (op == OP_RTYPE) && ((funct == FN_JR) || (funct == FN_JALR));

    // An ALU result still in EX is only a hazard when ID needs it now, i.e. for a compare or jr.
    assign ex_hit_rs  = ex_wr_en && (ex_wr_reg == rs) && (ex_memrd || is_branch || is_jr);
    assign ex_hit_rt  = ex_wr_en && (ex_wr_reg == rt) && (ex_memrd || is_branch || is_jr);
    assign mem_hit_rs = (FORWARD == 0) && mem_wr_en && (mem_wr_reg == rs);
    assign mem_hit_rt = (FORWARD == 0) && mem_wr_en && (mem_wr_reg == rt);

    assign hz = if_valid &&
                (((rs != '0) && (ex_hit_rs || mem_hit_rs)) ||
                 (dec_uses_rt && (rt != '0) && (ex_hit_rt || mem_hit_rt)));

    always_comb begin
        taken = 1'b0;
        case (op)
            OP_BLTZ: taken = (op_a < 0);
            OP_BEQ:  taken = (op_a == op_b);
            OP_BNE:  taken = (op_a != op_b);
            OP_BLEZ: taken = (op_a <= 0);
            OP_BGTZ: taken = (op_a > 0);
            default: taken = 1'b0;
        endcase
    end

    assign id_ready    = ~(hz | ex_stall);
    assign redirect    = if_valid & ~hz & ~ex_stall & (taken | is_jr);
    assign redirect_pc = is_jr ? op_a : br_target;

    // ID/EX boundary
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idex_valid <= 1'b0;
            idex_regwr <= 1'b0;
            idex_pc    <= '0;
            idex_bus_a <= '0;
            idex_bus_b <= '0;
            idex_imm   <= '0;
            idex_rs    <= '0;
            idex_rt    <= '0;
            idex_wrreg <= '0;
            idex_ctl   <= '0;
        end else if (ex_stall) begin
            idex_valid <= idex_valid;
        end else if (hz || !if_valid) begin
            idex_valid <= 1'b0;
            idex_regwr <= 1'b0;
        end else begin
            idex_valid <= 1'b1;
            idex_regwr <= dec_regwr && (if_instr != '0);
            idex_pc    <= if_pc;
            idex_bus_a <= op_a;
            idex_bus_b <= op_b;
            idex_imm   <= imm_sext;
            idex_rs    <= rs;
            idex_rt    <= rt;
            idex_wrreg <= (op == OP_RTYPE) ? rd : rt;
            idex_ctl   <= dec_ctl;
        end
    end

endmodule

// File: tb/tb_pipeline_id_stage.sv
// Scoreboard bench for pipeline_id_stage: directed decode vectors, FORWARD=1 and FORWARD=0 instances.
module tb_pipeline_id_stage;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        if_valid, dec_regwr, dec_uses_rt, ex_stall;
    logic [31:0] if_pc, if_instr;
    logic [23:0] dec_ctl;
    logic        ex_wr_en, ex_memrd, mem_wr_en, wb_wr_en;
    logic [4:0]  ex_wr_reg, mem_wr_reg, wb_wr_reg;
    logic [31:0] mem_data, wb_data;

    logic        id_ready, redirect, idex_valid, idex_regwr;
    logic [31:0] redirect_pc, idex_pc, idex_bus_a, idex_bus_b, idex_imm;
    logic [4:0]  idex_rs, idex_rt, idex_wrreg;
    logic [23:0] idex_ctl;

    logic        id_ready_f0, redirect_f0, idex_valid_f0, idex_regwr_f0;
    logic [31:0] redirect_pc_f0, idex_pc_f0, idex_bus_a_f0, idex_bus_b_f0, idex_imm_f0;
    logic [4:0]  idex_rs_f0, idex_rt_f0, idex_wrreg_f0;
    logic [23:0] idex_ctl_f0;

    pipeline_id_stage #(.XLEN(32), .NREG(32), .CTL_W(24), .FORWARD(1)) dut (
        .clk(clk), .reset(reset), .if_valid(if_valid), .if_pc(if_pc), .if_instr(if_instr),
        .dec_ctl(dec_ctl), .dec_regwr(dec_regwr), .dec_uses_rt(dec_uses_rt), .ex_stall(ex_stall),
        .ex_wr_en(ex_wr_en), .ex_wr_reg(ex_wr_reg), .ex_memrd(ex_memrd),
        .mem_wr_en(mem_wr_en), .mem_wr_reg(mem_wr_reg), .mem_data(mem_data),
        .wb_wr_en(wb_wr_en), .wb_wr_reg(wb_wr_reg), .wb_data(wb_data),
        .id_ready(id_ready), .redirect(redirect), .redirect_pc(redirect_pc),
        .idex_valid(idex_valid), .idex_pc(idex_pc), .idex_bus_a(idex_bus_a),
        .idex_bus_b(idex_bus_b), .idex_imm(idex_imm), .idex_rs(idex_rs), .idex_rt(idex_rt),
        .idex_wrreg(idex_wrreg), .idex_regwr(idex_regwr), .idex_ctl(idex_ctl)
    );

    pipeline_id_stage #(.XLEN(32), .NREG(32), .CTL_W(24), .FORWARD(0)) dut_f0 (
        .clk(clk), .reset(reset), .if_valid(if_valid), .if_pc(if_pc), .if_instr(if_instr),
        .dec_ctl(dec_ctl), .dec_regwr(dec_regwr), .dec_uses_rt(dec_uses_rt), .ex_stall(ex_stall),
        .ex_wr_en(ex_wr_en), .ex_wr_reg(ex_wr_reg), .ex_memrd(ex_memrd),
        .mem_wr_en(mem_wr_en), .mem_wr_reg(mem_wr_reg), .mem_data(mem_data),
        .wb_wr_en(wb_wr_en), .wb_wr_reg(wb_wr_reg), .wb_data(wb_data),
        .id_ready(id_ready_f0), .redirect(redirect_f0), .redirect_pc(redirect_pc_f0),
        .idex_valid(idex_valid_f0), .idex_pc(idex_pc_f0), .idex_bus_a(idex_bus_a_f0),
        .idex_bus_b(idex_bus_b_f0), .idex_imm(idex_imm_f0), .idex_rs(idex_rs_f0),
        .idex_rt(idex_rt_f0), .idex_wrreg(idex_wrreg_f0), .idex_regwr(idex_regwr_f0),
        .idex_ctl(idex_ctl_f0)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc, a, b, imm;
        logic [4:0]  rs, rt, wr;
        logic        regwr;
        logic [23:0] ctl;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input logic [31:0] pc, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] imm, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] wr, input logic regwr, input logic [23:0] ctl);
        exp_t e;
        e.pc = pc; e.a = a; e.b = b; e.imm = imm;
        e.rs = rs; e.rt = rt; e.wr = wr; e.regwr = regwr; e.ctl = ctl;
        q.push_back(e);
    endtask

    // Monitor: every edge that loads a new ID/EX entry is compared against the next expectation.
    initial begin
        logic stall_prev;
        exp_t e;
        forever begin
            @(posedge clk);
            stall_prev = ex_stall;
            #1;
            if (idex_valid && !stall_prev) begin
                if (q.size() == 0) begin
                    check("sb_unexpected_entry", idex_pc, 32'hFFFF_FFFF);
                end else begin
                    e = q.pop_front();
                    check("sb_pc",    idex_pc,    e.pc);
                    check("sb_bus_a", idex_bus_a, e.a);
                    check("sb_bus_b", idex_bus_b, e.b);
                    check("sb_imm",   idex_imm,   e.imm);
                    check("sb_rs",    32'(idex_rs),    32'(e.rs));
                    check("sb_rt",    32'(idex_rt),    32'(e.rt));
                    check("sb_wrreg", 32'(idex_wrreg), 32'(e.wr));
                    check("sb_regwr", 32'(idex_regwr), 32'(e.regwr));
                    check("sb_ctl",   32'(idex_ctl),   32'(e.ctl));
                end
            end
        end
    end

    task automatic idle_in();
        if_valid = 0; if_pc = '0; if_instr = '0; dec_ctl = '0; dec_regwr = 0; dec_uses_rt = 0;
        ex_stall = 0; ex_wr_en = 0; ex_wr_reg = '0; ex_memrd = 0;
        mem_wr_en = 0; mem_wr_reg = '0; mem_data = '0;
        wb_wr_en = 0; wb_wr_reg = '0; wb_data = '0;
    endtask

    task automatic drive(input logic [31:0] instr, input logic [31:0] pc, input logic [23:0] ctl,
                         input logic regwr, input logic uses_rt);
        if_valid = 1; if_instr = instr; if_pc = pc; dec_ctl = ctl;
        dec_regwr = regwr; dec_uses_rt = uses_rt;
    endtask

    task automatic wb_write(input logic [4:0] r, input logic [31:0] d);
        @(negedge clk);
        idle_in();
        wb_wr_en = 1; wb_wr_reg = r; wb_data = d;
    endtask

    initial begin
        idle_in();
        @(posedge clk);
        #1;
        check("reset_idex_valid", 32'(idex_valid), 32'h0);
        check("reset_idex_pc",    idex_pc,         32'h0);
        check("reset_idex_bus_a", idex_bus_a,      32'h0);
        check("reset_idex_ctl",   32'(idex_ctl),   32'h0);
        check("reset_id_ready",   32'(id_ready),   32'h1);
        @(negedge clk);
        reset = 1;

        wb_write(5'd2, 32'd5);
        wb_write(5'd8, 32'h0000_1000);
        wb_write(5'd0, 32'h0000_DEAD);

        // r0 reads zero even after a write attempt
        @(negedge clk); idle_in();
        drive(32'h0002_4820, 32'h200, 24'h0000A1, 1, 1);
        push(32'h200, 32'h0, 32'd5, 32'h4820, 5'd0, 5'd2, 5'd9, 1, 24'h0000A1);

        // write-through: r3 written and read in the same cycle
        @(negedge clk); idle_in();
        wb_wr_en = 1; wb_wr_reg = 5'd3; wb_data = 32'd7;
        drive(32'h0062_5020, 32'h204, 24'h0000A2, 1, 1);
        push(32'h204, 32'd7, 32'd5, 32'h5020, 5'd3, 5'd2, 5'd10, 1, 24'h0000A2);

        // load-use: lw r8 in EX, add r9,r8,r8 in ID
        @(negedge clk); idle_in();
        ex_wr_en = 1; ex_wr_reg = 5'd8; ex_memrd = 1;
        drive(32'h0108_4820, 32'h208, 24'h0000A3, 1, 1);
        #1;
        check("loaduse_id_ready", 32'(id_ready), 32'h0);
        check("loaduse_redirect", 32'(redirect), 32'h0);
        @(negedge clk);
        check("loaduse_bubble", 32'(idex_valid), 32'h0);
        idle_in();
        mem_wr_en = 1; mem_wr_reg = 5'd8; mem_data = 32'h0000_1234;
        drive(32'h0108_4820, 32'h208, 24'h0000A3, 1, 1);
        push(32'h208, 32'h1234, 32'h1234, 32'h4820, 5'd8, 5'd8, 5'd9, 1, 24'h0000A3);
        #1;
        check("loaduse_release_ready", 32'(id_ready), 32'h1);

        // beq r1,r2 taken with r1 forwarded from MEM; target wraps below if_pc
        @(negedge clk); idle_in();
        mem_wr_en = 1; mem_wr_reg = 5'd1; mem_data = 32'd5;
        drive(32'h1022_FFFE, 32'h100, 24'h0000B1, 0, 1);
        push(32'h100, 32'd5, 32'd5, 32'hFFFF_FFFE, 5'd1, 5'd2, 5'd2, 0, 24'h0000B1);
        #1;
        check("beq_redirect",    32'(redirect), 32'h1);
        check("beq_redirect_pc", redirect_pc,   32'h0000_00F8);
        check("beq_id_ready",    32'(id_ready), 32'h1);

        // bne with equal operands: not taken
        @(negedge clk); idle_in();
        mem_wr_en = 1; mem_wr_reg = 5'd1; mem_data = 32'd5;
        drive(32'h1422_FFFE, 32'h104, 24'h0000B2, 0, 1);
        push(32'h104, 32'd5, 32'd5, 32'hFFFF_FFFE, 5'd1, 5'd2, 5'd2, 0, 24'h0000B2);
        #1;
        check("bne_redirect", 32'(redirect), 32'h0);

        // bltz on a forwarded negative value
        @(negedge clk); idle_in();
        mem_wr_en = 1; mem_wr_reg = 5'd11; mem_data = 32'hFFFF_FFFF;
        drive(32'h0560_0004, 32'h300, 24'h0000B3, 0, 0);
        push(32'h300, 32'hFFFF_FFFF, 32'h0, 32'h4, 5'd11, 5'd0, 5'd0, 0, 24'h0000B3);
        #1;
        check("bltz_redirect",    32'(redirect), 32'h1);
        check("bltz_redirect_pc", redirect_pc,   32'h0000_0310);

        // branch target wraps mod 2^32
        @(negedge clk); idle_in();
        drive(32'h1000_0001, 32'hFFFF_FFFC, 24'h0000B4, 0, 1);
        push(32'hFFFF_FFFC, 32'h0, 32'h0, 32'h1, 5'd0, 5'd0, 5'd0, 0, 24'h0000B4);
        #1;
        check("wrap_redirect",    32'(redirect), 32'h1);
        check("wrap_redirect_pc", redirect_pc,   32'h0);

        // jr r2
        @(negedge clk); idle_in();
        drive(32'h0040_0008, 32'h400, 24'h0000C1, 0, 0);
        push(32'h400, 32'd5, 32'h0, 32'h8, 5'd2, 5'd0, 5'd0, 0, 24'h0000C1);
        #1;
        check("jr_redirect",    32'(redirect), 32'h1);
        check("jr_redirect_pc", redirect_pc,   32'd5);

        // EX back-pressure for 3 cycles while a taken branch waits in ID
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); idle_in();
            ex_stall = 1;
            drive(32'h1000_0001, 32'h600, 24'h0000C2, 0, 1);
            #1;
            check("stall_id_ready",   32'(id_ready),   32'h0);
            check("stall_redirect",   32'(redirect),   32'h0);
            check("stall_idex_valid", 32'(idex_valid), 32'h1);
            check("stall_idex_pc",    idex_pc,         32'h400);
            check("stall_idex_bus_a", idex_bus_a,      32'd5);
        end
        @(negedge clk); idle_in();
        drive(32'h1000_0001, 32'h600, 24'h0000C2, 0, 1);
        push(32'h600, 32'h0, 32'h0, 32'h1, 5'd0, 5'd0, 5'd0, 0, 24'h0000C2);
        #1;
        check("unstall_redirect_pc", redirect_pc, 32'h604);

        // branch operand produced by an ALU op in EX: one bubble
        @(negedge clk); idle_in();
        ex_wr_en = 1; ex_wr_reg = 5'd2;
        drive(32'h1022_0003, 32'h500, 24'h0000D1, 0, 1);
        #1;
        check("brhz_id_ready", 32'(id_ready), 32'h0);
        check("brhz_redirect", 32'(redirect), 32'h0);
        @(negedge clk); idle_in();
        mem_wr_en = 1; mem_wr_reg = 5'd2; mem_data = 32'd9;
        drive(32'h1022_0003, 32'h500, 24'h0000D1, 0, 1);
        push(32'h500, 32'h0, 32'd9, 32'h3, 5'd1, 5'd2, 5'd2, 0, 24'h0000D1);
        #1;
        check("brhz_after_redirect", 32'(redirect), 32'h0);

        // a load targeting r0 never causes a stall
        @(negedge clk); idle_in();
        ex_wr_en = 1; ex_wr_reg = 5'd0; ex_memrd = 1;
        drive(32'h0000_7020, 32'h510, 24'h0000D2, 1, 1);
        push(32'h510, 32'h0, 32'h0, 32'h7020, 5'd0, 5'd0, 5'd14, 1, 24'h0000D2);
        #1;
        check("r0_no_hazard", 32'(id_ready), 32'h1);

        // all-zero instruction never writes
        @(negedge clk); idle_in();
        drive(32'h0, 32'h520, 24'h0000D3, 1, 1);
        push(32'h520, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0, 0, 24'h0000D3);

        // MEM-stage producer: FORWARD=1 forwards, FORWARD=0 stalls until WB
        @(negedge clk); idle_in();
        mem_wr_en = 1; mem_wr_reg = 5'd4; mem_data = 32'h55;
        drive(32'h0080_6020, 32'h700, 24'h0000E1, 1, 1);
        push(32'h700, 32'h55, 32'h0, 32'h6020, 5'd4, 5'd0, 5'd12, 1, 24'h0000E1);
        #1;
        check("fwd1_id_ready", 32'(id_ready),    32'h1);
        check("fwd0_id_ready", 32'(id_ready_f0), 32'h0);
        @(negedge clk);
        check("fwd0_bubble", 32'(idex_valid_f0), 32'h0);
        idle_in();
        wb_wr_en = 1; wb_wr_reg = 5'd4; wb_data = 32'h66;
        drive(32'h0080_6020, 32'h700, 24'h0000E1, 1, 1);
        push(32'h700, 32'h66, 32'h0, 32'h6020, 5'd4, 5'd0, 5'd12, 1, 24'h0000E1);
        #1;
        check("fwd0_wb_ready", 32'(id_ready_f0), 32'h1);
        @(negedge clk);
        check("fwd0_idex_valid", 32'(idex_valid_f0), 32'h1);
        check("fwd0_idex_bus_a", idex_bus_a_f0,      32'h66);

        // reset asserted in the middle of a load-use stall
        idle_in();
        ex_wr_en = 1; ex_wr_reg = 5'd8; ex_memrd = 1;
        drive(32'h0108_4820, 32'h800, 24'h0000F1, 1, 1);
        #1;
        check("rst_stall_ready", 32'(id_ready), 32'h0);
        #1;
        reset = 0;
        #1;
        check("rst_async_valid",    32'(idex_valid),    32'h0);
        check("rst_async_pc",       idex_pc,            32'h0);
        check("rst_async_valid_f0", 32'(idex_valid_f0), 32'h0);
        @(negedge clk);
        reset = 1;
        idle_in();
        wb_wr_en = 1; wb_wr_reg = 5'd2; wb_data = 32'd9;
        drive(32'h0043_6820, 32'h900, 24'h0000F2, 1, 1);
        push(32'h900, 32'd9, 32'h0, 32'h6820, 5'd2, 5'd3, 5'd13, 1, 24'h0000F2);
        #1;
        check("post_rst_ready", 32'(id_ready), 32'h1);

        @(negedge clk); idle_in();
        repeat (3) @(negedge clk);
        check("sb_drained", 32'(q.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
